// File: rtl/level_scroller_pkg.sv
// level_scroller_pkg
//   Shared types and defaults for the obstacle level sequencer.
//   - state_t   : sequencer states
//   - DEF_*     : default parameter values used by level_scroller
//   - init_pos  : starting x position of lane i (lanes evenly spread)
package level_scroller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    PAUSED = 3'd2,
    LOST   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_NUM_OBJ    = 4;
  localparam int DEF_POS_W      = 11;
  localparam int DEF_TIME_W     = 11;
  localparam int DEF_SCREEN_W   = 700;
  localparam int DEF_BASE_STEP  = 10;
  localparam int DEF_STEP_INC   = 2;
  localparam int DEF_LEVEL_LEN  = 200;
  localparam int DEF_NUM_LEVELS = 4;

  // Lanes start evenly spaced across the screen.
  function automatic int unsigned init_pos(int unsigned i, int unsigned screen_w,
                                           int unsigned num_obj);
    return i * (screen_w / num_obj);
  endfunction

endpackage

// File: rtl/level_scroller_obj.sv
// obj_lane
//   One obstacle position register with modular advance.
//   Ports:
//     clk      in   system clock
//     reset_n  in   synchronous active-low reset (loads INIT_POS)
//     load     in   reload INIT_POS (priority over adv)
//     adv      in   advance position by step, wrapping modulo SCREEN_W
//     step     in   pixels to advance
//     pos      out  current position
module obj_lane #(
  parameter int          POS_W    = 11,
  parameter int          SCREEN_W = 700,
  parameter int unsigned INIT_POS = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             adv,
  input  logic [POS_W-1:0] step,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W:0]   WRAP = (POS_W+1)'(SCREEN_W);
  localparam logic [POS_W-1:0] INIT = POS_W'(INIT_POS);

  // One extra bit so pos + step cannot overflow before the wrap compare.
  logic [POS_W:0] sum;
  assign sum = {1'b0, pos} + {1'b0, step};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos <= INIT;
    end else if (load) begin
      pos <= INIT;
    end else if (adv) begin
      // Subtract rather than clear so the overshoot carries into the next lap.
      pos <= (sum >= WRAP) ? POS_W'(sum - WRAP) : POS_W'(sum);
    end
  end

endmodule

// File: rtl/level_scroller.sv
// level_scroller
//   Level sequencer and obstacle scroller. Moves NUM_OBJ lanes by the
//   current step on each frame tick, times each level, raises the step per
//   level, pulses win at each level end and flags game completion.
//   Ports:
//     clk          in   system clock
//     reset_n      in   synchronous active-low reset
//     tick         in   frame enable (one clk wide)
//     start        in   begin / restart a game
//     pause        in   level-sensitive freeze request
//     menu_screen  in   abort to IDLE with reset values
//     player_lost  in   collision report
//     obj_pos      out  packed lane positions, lane i at [i*POS_W +: POS_W]
//     game_time    out  ticks elapsed in the current level
//     level        out  current level index
//     step         out  current per-tick step
//     win          out  one-cycle pulse after each level end
//     game_over    out  high while in DONE
//     lost         out  high while in LOST
//
//   state  | meaning
//   IDLE   | waiting for start, reset values shown
//   RUN    | lanes scroll and level timer counts on tick
//   PAUSED | everything frozen until pause drops
//   LOST   | collision seen, values frozen for display
//   DONE   | last level finished, level/step held
module level_scroller
  import level_scroller_pkg::*;
#(
  parameter int   NUM_OBJ    = DEF_NUM_OBJ,
  parameter int   POS_W      = DEF_POS_W,
  parameter int   TIME_W     = DEF_TIME_W,
  parameter int   SCREEN_W   = DEF_SCREEN_W,
  parameter int   BASE_STEP  = DEF_BASE_STEP,
  parameter int   STEP_INC   = DEF_STEP_INC,
  parameter int   LEVEL_LEN  = DEF_LEVEL_LEN,
  parameter int   NUM_LEVELS = DEF_NUM_LEVELS,
  localparam int  LVL_W      = $clog2(NUM_LEVELS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     menu_screen,
  input  logic                     player_lost,
  output logic [NUM_OBJ*POS_W-1:0] obj_pos,
  output logic [TIME_W-1:0]        game_time,
  output logic [LVL_W-1:0]         level,
  output logic [POS_W-1:0]         step,
  output logic                     win,
  output logic                     game_over,
  output logic                     lost
);

  localparam logic [TIME_W-1:0] LAST_TIME  = TIME_W'(LEVEL_LEN - 1);
  localparam logic [LVL_W-1:0]  LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [POS_W-1:0]  STEP_RST   = POS_W'(BASE_STEP);
  localparam logic [POS_W-1:0]  STEP_ADD   = POS_W'(STEP_INC);

  state_t state;

  logic level_end;
  logic lose;
  logic restart;
  logic lane_load;
  logic lane_adv;

  // Lane control mirrors the FSM priority: menu > loss > level end > pause > tick.
  always_comb begin
    level_end = (state == RUN) && tick && (game_time == LAST_TIME);
    lose      = ((state == RUN) || (state == PAUSED)) && player_lost;
    restart   = ((state == LOST) || (state == DONE)) && start;
    lane_load = menu_screen || (!lose && (level_end || restart));
    lane_adv  = !menu_screen && !lose && !level_end &&
                (state == RUN) && !pause && tick;
  end

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_lane
    obj_lane #(
      .POS_W   (POS_W),
      .SCREEN_W(SCREEN_W),
      .INIT_POS(init_pos(i, SCREEN_W, NUM_OBJ))
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (lane_load),
      .adv    (lane_adv),
      .step   (step),
      .pos    (obj_pos[i*POS_W +: POS_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      game_time <= '0;
      level     <= '0;
      step      <= STEP_RST;
      win       <= 1'b0;
      game_over <= 1'b0;
      lost      <= 1'b0;
    end else begin
      win <= 1'b0;
      if (menu_screen) begin
        state     <= IDLE;
        game_time <= '0;
        level     <= '0;
        step      <= STEP_RST;
        game_over <= 1'b0;
        lost      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) state <= RUN;
          end
          RUN: begin
            if (player_lost) begin
              state <= LOST;
              lost  <= 1'b1;
            end else if (level_end) begin
              game_time <= '0;
              win       <= 1'b1;
              if (level != LAST_LEVEL) begin
                level <= level + LVL_W'(1);
                step  <= step + STEP_ADD;
              end else begin
                state     <= DONE;
                game_over <= 1'b1;
              end
            end else if (pause) begin
              state <= PAUSED;
            end else if (tick) begin
              game_time <= game_time + TIME_W'(1);
            end
          end
          PAUSED: begin
            if (player_lost) begin
              state <= LOST;
              lost  <= 1'b1;
            end else if (!pause) begin
              state <= RUN;
            end
          end
          LOST, DONE: begin
            if (start) begin
              state     <= RUN;
              game_time <= '0;
              level     <= '0;
              step      <= STEP_RST;
              game_over <= 1'b0;
              lost      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_level_scroller.sv
module tb_level_scroller;

  localparam int NUM_OBJ = 4;
  localparam int POS_W   = 11;
  localparam int TIME_W  = 11;
  localparam int LVL_W   = 2;

  logic                     clk;
  logic                     reset_n;
  logic                     tick;
  logic                     start;
  logic                     pause;
  logic                     menu_screen;
  logic                     player_lost;
  logic [NUM_OBJ*POS_W-1:0] obj_pos;
  logic [TIME_W-1:0]        game_time;
  logic [LVL_W-1:0]         level;
  logic [POS_W-1:0]         step;
  logic                     win;
  logic                     game_over;
  logic                     lost;

  level_scroller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .start      (start),
    .pause      (pause),
    .menu_screen(menu_screen),
    .player_lost(player_lost),
    .obj_pos    (obj_pos),
    .game_time  (game_time),
    .level      (level),
    .step       (step),
    .win        (win),
    .game_over  (game_over),
    .lost       (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic rn, st, pa, me, pl, tk;
    int   l0, l1, l3, gt, lv, sp;
    int   w, go, ls;
  } vec_t;

  vec_t vecs[19];

  function automatic int lane(int i);
    return int'(obj_pos[i*POS_W +: POS_W]);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic rn, logic st, logic pa, logic me, logic pl, logic tk);
    reset_n = rn; start = st; pause = pa; menu_screen = me; player_lost = pl; tick = tk;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset_start();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    idle_inputs();
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
    end
    idle_inputs();
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, ".l0"}, lane(0), 0);
    check({tag, ".l1"}, lane(1), 175);
    check({tag, ".l2"}, lane(2), 350);
    check({tag, ".l3"}, lane(3), 525);
    check({tag, ".gt"}, int'(game_time), 0);
    check({tag, ".lv"}, int'(level), 0);
    check({tag, ".sp"}, int'(step), 10);
    check({tag, ".win"}, int'(win), 0);
    check({tag, ".go"}, int'(game_over), 0);
    check({tag, ".lost"}, int'(lost), 0);
  endtask

  initial begin
    int wins;
    int lv_e, sp_e, gt_e;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //              rn st pa me pl tk   l0   l1   l3  gt lv sp  w go ls
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,   0, 175, 525, 0, 0, 10, 0, 0, 0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,   0, 175, 525, 0, 0, 10, 0, 0, 0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  10, 185, 535, 1, 0, 10, 0, 0, 0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  20, 195, 545, 2, 0, 10, 0, 0, 0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  30, 205, 555, 3, 0, 10, 0, 0, 0};
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,  30, 205, 555, 3, 0, 10, 0, 0, 0};
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,  30, 205, 555, 3, 0, 10, 0, 0, 0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  30, 205, 555, 3, 0, 10, 0, 0, 0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  40, 215, 565, 4, 0, 10, 0, 0, 0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,   0, 175, 525, 0, 0, 10, 0, 0, 0};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,   0, 175, 525, 0, 0, 10, 0, 0, 0};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,   0, 175, 525, 0, 0, 10, 0, 0, 0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,   0, 175, 525, 0, 0, 10, 0, 0, 0};
    vecs[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,   0, 175, 525, 0, 0, 10, 0, 0, 0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  10, 185, 535, 1, 0, 10, 0, 0, 0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,  10, 185, 535, 1, 0, 10, 0, 0, 1};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  10, 185, 535, 1, 0, 10, 0, 0, 1};
    vecs[17] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,   0, 175, 525, 0, 0, 10, 0, 0, 0};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  10, 185, 535, 1, 0, 10, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rn, vecs[i].st, vecs[i].pa, vecs[i].me, vecs[i].pl, vecs[i].tk);
      cycle();
      check($sformatf("v%0d.l0", i), lane(0), vecs[i].l0);
      check($sformatf("v%0d.l1", i), lane(1), vecs[i].l1);
      check($sformatf("v%0d.l3", i), lane(3), vecs[i].l3);
      check($sformatf("v%0d.gt", i), int'(game_time), vecs[i].gt);
      check($sformatf("v%0d.lv", i), int'(level), vecs[i].lv);
      check($sformatf("v%0d.sp", i), int'(step), vecs[i].sp);
      check($sformatf("v%0d.win", i), int'(win), vecs[i].w);
      check($sformatf("v%0d.go", i), int'(game_over), vecs[i].go);
      check($sformatf("v%0d.lost", i), int'(lost), vecs[i].ls);
    end

    // Modular wrap: lane3 goes 695 -> 705-700 = 5, not 0.
    do_reset_start();
    ticks(17);
    check("wrap.l3_pre", lane(3), 695);
    ticks(1);
    check("wrap.l3", lane(3), 5);
    check("wrap.l0", lane(0), 180);
    check("wrap.l2", lane(2), 530);

    // Full game with back-to-back ticks, checked against an arithmetic model.
    do_reset_start();
    wins = 0;
    for (int k = 0; k < 800; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      lv_e = (k + 1) / 200;
      if (lv_e > 3) lv_e = 3;
      sp_e = 10 + 2 * lv_e;
      gt_e = (k + 1) % 200;
      if (win) wins++;
      check($sformatf("run%0d.win", k), int'(win), ((k + 1) % 200 == 0) ? 1 : 0);
      check($sformatf("run%0d.gt", k), int'(game_time), gt_e);
      check($sformatf("run%0d.lv", k), int'(level), lv_e);
      check($sformatf("run%0d.sp", k), int'(step), sp_e);
      check($sformatf("run%0d.l0", k), lane(0), (sp_e * gt_e) % 700);
      check($sformatf("run%0d.l3", k), lane(3), (525 + sp_e * gt_e) % 700);
      check($sformatf("run%0d.go", k), int'(game_over), (k == 799) ? 1 : 0);
    end
    check("game.wins", wins, 4);
    idle_inputs();
    cycle();
    check("done.win_drop", int'(win), 0);
    ticks(5);
    check("done.l0", lane(0), 0);
    check("done.l3", lane(3), 525);
    check("done.gt", int'(game_time), 0);
    check("done.lv", int'(level), 3);
    check("done.sp", int'(step), 16);
    check("done.go", int'(game_over), 1);
    check("done.win", int'(win), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    check_reset_vals("restart");
    ticks(1);
    check("restart.l0", lane(0), 10);
    check("restart.gt", int'(game_time), 1);

    // Loss on the level-end tick suppresses the win pulse and freezes time.
    do_reset_start();
    ticks(199);
    check("lose.gt_pre", int'(game_time), 199);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    check("lose.lost", int'(lost), 1);
    check("lose.win", int'(win), 0);
    check("lose.gt", int'(game_time), 199);
    check("lose.l0", lane(0), 1990 % 700);
    idle_inputs();
    cycle();
    check("lose.win_after", int'(win), 0);
    check("lose.lv", int'(level), 0);
    check("lose.lost_hold", int'(lost), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    check_reset_vals("menu");

    // Pause for 50 ticks mid-level, then reset while paused.
    do_reset_start();
    ticks(100);
    check("pause.gt_pre", int'(game_time), 100);
    for (int k = 0; k < 50; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
    end
    check("pause.gt", int'(game_time), 100);
    check("pause.l0", lane(0), 300);
    check("pause.l1", lane(1), 475);
    check("pause.l3", lane(3), 125);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check_reset_vals("prst");
    ticks(3);
    check("prst.idle_l0", lane(0), 0);
    check("prst.idle_gt", int'(game_time), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
